// File: rtl/interrupt_ctrl.sv
// Fixed-priority interrupt controller owning IF/IE, with edge detection and a req/ack handshake to the CPU.
// Optional INT_WAKE_EN adds a registered O_WAKE output (|(IF & IE), independent of IME).
module interrupt_ctrl #(
    parameter int          NUM_IRQ       = 5,
    parameter logic [15:0] IF_ADDR       = 16'hFF0F,
    parameter logic [15:0] IE_ADDR       = 16'hFFFF,
    parameter logic [15:0] VECTOR_BASE   = 16'h0040,
    parameter logic [15:0] VECTOR_STRIDE = 16'h0008
) (
    input  logic               I_CLOCK,
    input  logic               I_RESET,
    input  logic [NUM_IRQ-1:0] I_IRQ,
    input  logic [15:0]        I_ADDR,
    input  logic [7:0]         I_WDATA,
    input  logic               I_WE_L,
    input  logic               I_RE_L,
    output logic [7:0]         O_RDATA,
    output logic               O_RVALID,
    input  logic               I_IME,
    output logic               O_INT_REQ,
    output logic [15:0]        O_INT_VECTOR,
    input  logic               I_INT_ACK,
    output logic [NUM_IRQ-1:0] O_IF,
    output logic [NUM_IRQ-1:0] O_IE
`ifdef INT_WAKE_EN
    ,
    output logic               O_WAKE
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [NUM_IRQ-1:0] r_prev;
    logic [NUM_IRQ-1:0] r_if;
    logic [NUM_IRQ-1:0] r_ie;
    logic [2:0]         r_idx;
    logic [15:0]        r_vec;
    logic               r_req;
    logic [7:0]         r_rdata;
    logic               r_rvalid;

    logic [NUM_IRQ-1:0] w_pend;
    logic [NUM_IRQ-1:0] w_rise;
    logic [NUM_IRQ-1:0] w_lat_mask;
    logic [NUM_IRQ-1:0] w_if_next;
    logic               w_lat_pend;
    logic [2:0]         w_win;
    logic [15:0]        w_vec;
    logic               w_latch;
    logic               w_ack_clr;
    logic               w_wr_if;
    logic               w_wr_ie;
    logic               w_rd_if;
    logic               w_rd_ie;
    logic [7:0]         w_rd_if_val;
    logic [7:0]         w_rd_ie_val;

    assign w_pend  = r_if & r_ie;
    assign w_rise  = I_IRQ & ~r_prev;
    assign w_wr_if = ~I_WE_L && (I_ADDR == IF_ADDR);
    assign w_wr_ie = ~I_WE_L && (I_ADDR == IE_ADDR);
    assign w_rd_if = ~I_RE_L && (I_ADDR == IF_ADDR);
    assign w_rd_ie = ~I_RE_L && (I_ADDR == IE_ADDR);
    assign w_vec   = VECTOR_BASE + ({13'd0, w_win} * VECTOR_STRIDE);

    // Priority encode (lowest index wins) and decode of the latched channel.
    always_comb begin
        w_win      = 3'd0;
        w_lat_mask = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            w_win = w_pend[i] ? 3'(i) : w_win;
        end
        for (int i = 0; i < NUM_IRQ; i++) begin
            w_lat_mask[i] = (r_idx == 3'(i));
        end
        w_lat_pend = |(w_pend & w_lat_mask);
    end

    // Handshake next-state; withdrawal wins over a late ack so a cleared source is never acknowledged.
    always_comb begin
        w_next    = r_state;
        w_latch   = 1'b0;
        w_ack_clr = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (I_IME && (|w_pend)) begin
                    w_next  = S_REQ;
                    w_latch = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_REQ: begin
                if (!I_IME || !w_lat_pend) begin
                    w_next = S_IDLE;
                end else if (I_INT_ACK) begin
                    w_next    = S_DONE;
                    w_ack_clr = 1'b1;
                end else begin
                    w_next = S_REQ;
                end
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // IF update: CPU write, then ack clear, then source edges (edges always survive).
    always_comb begin
        w_if_next = w_wr_if ? I_WDATA[NUM_IRQ-1:0] : r_if;
        w_if_next = w_ack_clr ? (w_if_next & ~w_lat_mask) : w_if_next;
        w_if_next = w_if_next | w_rise;
        w_rd_if_val = 8'hFF;
        w_rd_if_val[NUM_IRQ-1:0] = r_if;
        w_rd_ie_val = 8'hFF;
        w_rd_ie_val[NUM_IRQ-1:0] = r_ie;
    end

    // All state and registered outputs.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            r_state  <= S_IDLE;
            r_prev   <= '0;
            r_if     <= '0;
            r_ie     <= '0;
            r_idx    <= 3'd0;
            r_vec    <= 16'h0000;
            r_req    <= 1'b0;
            r_rdata  <= 8'h00;
            r_rvalid <= 1'b0;
        end else begin
            r_state <= w_next;
            r_prev  <= I_IRQ;
            r_if    <= w_if_next;
            r_req   <= (w_next == S_REQ);
            if (w_wr_ie) begin
                r_ie <= I_WDATA[NUM_IRQ-1:0];
            end
            if (w_latch) begin
                r_idx <= w_win;
                r_vec <= w_vec;
            end
            if (w_rd_if) begin
                r_rdata  <= w_rd_if_val;
                r_rvalid <= 1'b1;
            end else if (w_rd_ie) begin
                r_rdata  <= w_rd_ie_val;
                r_rvalid <= 1'b1;
            end else begin
                r_rvalid <= 1'b0;
            end
        end
    end

`ifdef INT_WAKE_EN
    logic r_wake;

    // Wake flag for HALT/STOP exit, deliberately ignoring IME.
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            r_wake <= 1'b0;
        end else begin
            r_wake <= |w_pend;
        end
    end

    assign O_WAKE = r_wake;
`endif

    assign O_RDATA      = r_rdata;
    assign O_RVALID     = r_rvalid;
    assign O_INT_REQ    = r_req;
    assign O_INT_VECTOR = r_vec;
    assign O_IF         = r_if;
    assign O_IE         = r_ie;

endmodule

// File: tb/tb_interrupt_ctrl.sv
// Scoreboarded bench for interrupt_ctrl: read data and interrupt vectors are queued at stimulus time and checked when the DUT presents them.
module tb_interrupt_ctrl;

    localparam logic [15:0] IF_A = 16'hFF0F;
    localparam logic [15:0] IE_A = 16'hFFFF;

    logic        I_CLOCK;
    logic        I_RESET;
    logic [4:0]  I_IRQ;
    logic [15:0] I_ADDR;
    logic [7:0]  I_WDATA;
    logic        I_WE_L;
    logic        I_RE_L;
    logic [7:0]  O_RDATA;
    logic        O_RVALID;
    logic        I_IME;
    logic        O_INT_REQ;
    logic [15:0] O_INT_VECTOR;
    logic        I_INT_ACK;
    logic [4:0]  O_IF;
    logic [4:0]  O_IE;
`ifdef INT_WAKE_EN
    logic        O_WAKE;
`endif

    int n_total = 0;
    int n_bad   = 0;
    logic [7:0]  rd_q[$];
    logic [15:0] vec_q[$];
    logic        prev_req = 1'b0;

    interrupt_ctrl dut (
        .I_CLOCK      (I_CLOCK),
        .I_RESET      (I_RESET),
        .I_IRQ        (I_IRQ),
        .I_ADDR       (I_ADDR),
        .I_WDATA      (I_WDATA),
        .I_WE_L       (I_WE_L),
        .I_RE_L       (I_RE_L),
        .O_RDATA      (O_RDATA),
        .O_RVALID     (O_RVALID),
        .I_IME        (I_IME),
        .O_INT_REQ    (O_INT_REQ),
        .O_INT_VECTOR (O_INT_VECTOR),
        .I_INT_ACK    (I_INT_ACK),
        .O_IF         (O_IF),
        .O_IE         (O_IE)
`ifdef INT_WAKE_EN
        ,
        .O_WAKE       (O_WAKE)
`endif
    );

    initial I_CLOCK = 1'b0;
    always #5 I_CLOCK = ~I_CLOCK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge I_CLOCK);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        I_ADDR = a; I_WDATA = d; I_WE_L = 1'b0;
        cyc();
        I_WE_L = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input bit expect_data);
        I_ADDR = a; I_RE_L = 1'b0;
        if (expect_data) rd_q.push_back(exp);
        cyc();
        I_RE_L = 1'b1;
    endtask

    task automatic pulse_irq(input logic [4:0] m);
        I_IRQ = m;
        cyc();
        I_IRQ = 5'h00;
    endtask

    task automatic ack();
        I_INT_ACK = 1'b1;
        cyc();
        I_INT_ACK = 1'b0;
    endtask

    task automatic wait_req();
        int k;
        k = 0;
        while (!O_INT_REQ && k < 20) begin
            cyc();
            k++;
        end
        if (!O_INT_REQ) chk("req_timeout", 32'd0, 32'd1);
    endtask

    // Scoreboard monitor: pops expected read data on O_RVALID and expected vector on each new request.
    always @(negedge I_CLOCK) begin
        if (O_RVALID) begin
            if (rd_q.size() == 0) chk("rd_spurious", 32'd1, 32'd0);
            else chk("rdata", {24'd0, O_RDATA}, {24'd0, rd_q.pop_front()});
        end
        if (O_INT_REQ && !prev_req) begin
            if (vec_q.size() == 0) chk("req_spurious", 32'd1, 32'd0);
            else chk("vector", {16'd0, O_INT_VECTOR}, {16'd0, vec_q.pop_front()});
        end
        prev_req <= O_INT_REQ;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        I_RESET = 1'b1; I_IRQ = 5'h00; I_ADDR = 16'h0000; I_WDATA = 8'h00;
        I_WE_L = 1'b1; I_RE_L = 1'b1; I_IME = 1'b0; I_INT_ACK = 1'b0;
        cyc(3);
        I_RESET = 1'b0;
        cyc();
        chk("rst_if",  {27'd0, O_IF}, 32'd0);
        chk("rst_ie",  {27'd0, O_IE}, 32'd0);
        chk("rst_req", {31'd0, O_INT_REQ}, 32'd0);
        chk("rst_vec", {16'd0, O_INT_VECTOR}, 32'd0);
        chk("rst_rdata", {24'd0, O_RDATA}, 32'd0);
        chk("rst_rvalid", {31'd0, O_RVALID}, 32'd0);

        // Reads: unused bits read as 1; foreign address gives no valid and holds data.
        rd(IF_A, 8'hE0, 1'b1);
        rd(IE_A, 8'hE0, 1'b1);
        rd(16'hFF10, 8'h00, 1'b0);
        cyc(2);
        chk("rdata_hold", {24'd0, O_RDATA}, 32'h0000_00E0);

        // Single source on channel 2.
        wr(IE_A, 8'h1F);
        rd(IE_A, 8'hFF, 1'b1);
        I_IME = 1'b1;
        vec_q.push_back(16'h0050);
        pulse_irq(5'h04);
        chk("if_ch2", {27'd0, O_IF}, 32'h04);
        wait_req();
        ack();
        chk("ack_if", {27'd0, O_IF}, 32'd0);
        chk("ack_req_low", {31'd0, O_INT_REQ}, 32'd0);
        cyc();
        chk("gap_req_low", {31'd0, O_INT_REQ}, 32'd0);

        // Simultaneous 0 and 4: priority order.
        vec_q.push_back(16'h0040);
        vec_q.push_back(16'h0060);
        pulse_irq(5'h11);
        wait_req();
        ack();
        chk("if_after_ack0", {27'd0, O_IF}, 32'h10);
        wait_req();
        ack();
        chk("if_after_ack4", {27'd0, O_IF}, 32'd0);

        // Held-high source sets IF once.
        vec_q.push_back(16'h0048);
        I_IRQ = 5'h02;
        cyc();
        wait_req();
        ack();
        cyc(8);
        chk("held_if", {27'd0, O_IF}, 32'd0);
        chk("held_req", {31'd0, O_INT_REQ}, 32'd0);
        I_IRQ = 5'h00;
        cyc(2);

        // CPU clears IF while request is outstanding.
        vec_q.push_back(16'h0050);
        pulse_irq(5'h04);
        wait_req();
        wr(IF_A, 8'h00);
        cyc();
        chk("withdraw_req", {31'd0, O_INT_REQ}, 32'd0);
        chk("withdraw_if", {27'd0, O_IF}, 32'd0);
        cyc(2);
        chk("withdraw_stay", {31'd0, O_INT_REQ}, 32'd0);

        // Write IF=0 coinciding with channel 3 edge.
        I_IME = 1'b0;
        I_ADDR = IF_A; I_WDATA = 8'h00; I_WE_L = 1'b0; I_IRQ = 5'h08;
        cyc();
        I_WE_L = 1'b1; I_IRQ = 5'h00;
        chk("wr_vs_rise", {27'd0, O_IF}, 32'h08);
        rd(IF_A, 8'hE8, 1'b1);

        // IME drop withdraws without touching IF.
        I_IME = 1'b1;
        vec_q.push_back(16'h0058);
        wait_req();
        I_IME = 1'b0;
        cyc();
        chk("ime_withdraw", {31'd0, O_INT_REQ}, 32'd0);
        chk("ime_if_kept", {27'd0, O_IF}, 32'h08);

        // Ack outside REQ is ignored.
        wr(IF_A, 8'h02);
        ack();
        chk("stray_ack", {27'd0, O_IF}, 32'h02);
        wr(IF_A, 8'h00);

`ifdef INT_WAKE_EN
        wr(IE_A, 8'h01);
        pulse_irq(5'h01);
        cyc(2);
        chk("wake", {31'd0, O_WAKE}, 32'd1);
        chk("wake_no_req", {31'd0, O_INT_REQ}, 32'd0);
        wr(IF_A, 8'h00);
        wr(IE_A, 8'h1F);
`endif

        // Reset in the middle of a handshake.
        wr(IE_A, 8'h1F);
        I_IME = 1'b1;
        vec_q.push_back(16'h0040);
        pulse_irq(5'h01);
        wait_req();
        I_RESET = 1'b1; I_INT_ACK = 1'b1;
        cyc();
        I_RESET = 1'b0; I_INT_ACK = 1'b0; I_IME = 1'b0;
        chk("mid_rst_req", {31'd0, O_INT_REQ}, 32'd0);
        chk("mid_rst_if", {27'd0, O_IF}, 32'd0);
        chk("mid_rst_ie", {27'd0, O_IE}, 32'd0);
        chk("mid_rst_vec", {16'd0, O_INT_VECTOR}, 32'd0);
        cyc(3);

        chk("rd_q_empty", rd_q.size(), 32'd0);
        chk("vec_q_empty", vec_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
